// File: rtl/temp_link_pkg.sv
// rtl/temp_link_pkg.sv - shared types, frame constants and checksum for the temperature link
package temp_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int FRAME_BYTES   = 4;
    localparam int BITS_PER_BYTE = 10;

    // Field positions inside the id byte (B1)
    localparam int ALARM_BIT = 7;
    localparam int ID_LSB    = 0;

    function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                  input logic [7:0] b1,
                                                  input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/alarm_rr_arbiter.sv
// rtl/alarm_rr_arbiter.sv - three-way round-robin arbiter where alarmed requesters pre-empt the rest
// Ports:
//   tranclk, rst  : clock, synchronous active-high reset (pointer -> 2, core 0 first)
//   req[2:0]      : requesting cores
//   alarm[2:0]    : per-core high-priority flag
//   grant_en      : accept the current grant and move the pointer to the winner
//   grant[2:0]    : one-hot winner (zero when req is zero)
//   grant_idx     : binary index of the winner
module alarm_rr_arbiter
    import temp_link_pkg::*;
(
    input  logic       tranclk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] alarm,
    input  logic       grant_en,
    output logic [2:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] ptr_q;
    logic [2:0] cand;
    logic [2:0] sum;
    logic       found;

    always_ff @(posedge tranclk) begin
        if (rst) begin
            ptr_q <= 2'd2;
        end else if (grant_en && (req != 3'b000)) begin
            ptr_q <= grant_idx;
        end
    end

    // Alarmed requesters form the candidate set when any exist; the
    // pointer rotation itself is the same either way.
    always_comb begin
        cand      = ((req & alarm) != 3'b000) ? (req & alarm) : req;
        grant_idx = 2'd0;
        found     = 1'b0;
        sum       = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            sum = {1'b0, ptr_q} + 3'(k);
            if (sum >= 3'd3) begin
                sum = sum - 3'd3;
            end
            if (!found && cand[sum[1:0]]) begin
                found     = 1'b1;
                grant_idx = sum[1:0];
            end
        end
        grant = found ? (3'b001 << grant_idx) : 3'b000;
    end

endmodule

// File: rtl/temp_link_scheduler.sv
// rtl/temp_link_scheduler.sv - arbitrates three core temperature samples into framed UART packets
// Ports:
//   tranclk, rst      : bit-time clock, synchronous active-high reset
//   req[2:0]          : per-core sample request, held until ack
//   temp0/1/2         : per-core temperature
//   ack[2:0]          : one-cycle pulse when a core's sample is latched
//   tx                : registered UART line, idle high
//   busy              : grant through end of gap
//   frame_done        : pulse in the first gap cycle
module temp_link_scheduler
    import temp_link_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter logic [7:0] ALARM_TEMP = 8'd85,
    parameter int         GAP_BITS   = 2
) (
    input  logic       tranclk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] temp0,
    input  logic [7:0] temp1,
    input  logic [7:0] temp2,
    output logic [2:0] ack,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    state_t     state_q, state_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       tx_q, tx_d;
    logic [2:0] ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] temp_q, temp_d;
    logic [7:0] id_q, id_d;

    logic [2:0] alarm;
    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic       grant_en;
    logic [7:0] temp_sel;
    logic [7:0] cur_byte;

    assign alarm    = {temp2 >= ALARM_TEMP, temp1 >= ALARM_TEMP, temp0 >= ALARM_TEMP};
    assign grant_en = (state_q == IDLE);

    alarm_rr_arbiter u_arb (
        .tranclk   (tranclk),
        .rst       (rst),
        .req       (req),
        .alarm     (alarm),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        case (grant_idx)
            2'd1:    temp_sel = temp1;
            2'd2:    temp_sel = temp2;
            default: temp_sel = temp0;
        endcase
    end

    always_comb begin
        case (byte_idx_q)
            2'd0:    cur_byte = SYNC_BYTE;
            2'd1:    cur_byte = id_q;
            2'd2:    cur_byte = temp_q;
            default: cur_byte = frame_checksum(SYNC_BYTE, id_q, temp_q);
        endcase
    end

    // tx_d is the bit that will be on the line in the next cycle, so the
    // counters always describe the bit currently being driven.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        gap_cnt_d    = gap_cnt_q;
        tx_d         = tx_q;
        ack_d        = 3'b000;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        temp_d       = temp_q;
        id_d         = id_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (req != 3'b000) begin
                    state_d                = SEND;
                    ack_d                  = grant;
                    busy_d                 = 1'b1;
                    tx_d                   = 1'b0;
                    byte_idx_d             = 2'd0;
                    bit_idx_d              = 4'd0;
                    temp_d                 = temp_sel;
                    id_d                   = 8'h00;
                    id_d[ALARM_BIT]        = (temp_sel >= ALARM_TEMP);
                    id_d[ID_LSB +: 2]      = grant_idx;
                end
            end
            SEND: begin
                if (bit_idx_q == 4'(BITS_PER_BYTE - 1)) begin
                    bit_idx_d = 4'd0;
                    if (byte_idx_q == 2'(FRAME_BYTES - 1)) begin
                        state_d      = GAP;
                        byte_idx_d   = 2'd0;
                        gap_cnt_d    = 4'd0;
                        tx_d         = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_d       = 1'b0;
                    end
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    // Next bit 9 is the stop bit; bits 1..8 carry data LSB first.
                    if (bit_idx_q == 4'(BITS_PER_BYTE - 2)) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d = cur_byte[bit_idx_q[2:0]];
                    end
                end
            end
            GAP: begin
                tx_d = 1'b1;
                if (gap_cnt_q == 4'(GAP_BITS - 1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = 4'd0;
                    busy_d    = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge tranclk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_idx_q   <= 2'd0;
            bit_idx_q    <= 4'd0;
            gap_cnt_q    <= 4'd0;
            tx_q         <= 1'b1;
            ack_q        <= 3'b000;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            temp_q       <= 8'h00;
            id_q         <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            tx_q         <= tx_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            temp_q       <= temp_d;
            id_q         <= id_d;
        end
    end

    assign ack        = ack_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_temp_link_scheduler.sv
// tb/tb_temp_link_scheduler.sv - directed self-checking bench for temp_link_scheduler
module tb_temp_link_scheduler;

    logic       tranclk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] temp0, temp1, temp2;
    logic [2:0] ack;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    temp_link_scheduler dut (
        .tranclk    (tranclk),
        .rst        (rst),
        .req        (req),
        .temp0      (temp0),
        .temp1      (temp1),
        .temp2      (temp2),
        .ack        (ack),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 tranclk = ~tranclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        @(negedge tranclk);
        @(negedge tranclk);
        rst = 1'b0;
    endtask

    // Returns at the negedge of the first cycle with ack high (start bit of B0).
    task automatic wait_grant(input logic [2:0] exp_ack, input string tag, output int waited);
        waited = 0;
        do begin
            @(negedge tranclk);
            waited++;
        end while (ack == 3'b000 && waited < 100);
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        chk({tag, "_start"}, 32'(tx), 32'd0);
    endtask

    // Called in the grant+1 cycle; captures all 40 bits, then checks the gap.
    task automatic finish_packet(input logic [31:0] exp_pkt, input logic [2:0] late_req,
                                 input string tag);
        logic [39:0] line;
        logic [31:0] pkt;
        logic        frame_ok;
        int          fd_early;
        line[0]  = tx;
        fd_early = int'(frame_done);
        for (int i = 1; i < 40; i++) begin
            @(negedge tranclk);
            line[i] = tx;
            if (frame_done) fd_early++;
            if (i == 1) chk({tag, "_ack_pulse"}, 32'(ack), 32'd0);
            if (i == 39) req = late_req;
        end
        frame_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (line[10*k] !== 1'b0 || line[10*k+9] !== 1'b1) frame_ok = 1'b0;
            pkt[8*k +: 8] = line[10*k+1 +: 8];
        end
        chk({tag, "_bytes"}, pkt, exp_pkt);
        chk({tag, "_framing"}, 32'(frame_ok), 32'd1);
        chk({tag, "_fd_early"}, 32'(fd_early), 32'd0);
        @(negedge tranclk);
        chk({tag, "_fd_pulse"}, 32'(frame_done), 32'd1);
        chk({tag, "_gap1_tx"}, 32'(tx), 32'd1);
        chk({tag, "_gap1_busy"}, 32'(busy), 32'd1);
        @(negedge tranclk);
        chk({tag, "_fd_clear"}, 32'(frame_done), 32'd0);
        chk({tag, "_gap2_busy"}, 32'(busy), 32'd1);
        @(negedge tranclk);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int waited;
        int bad_ack;
        int bad_tx;
        rst   = 1'b1;
        req   = 3'b000;
        temp0 = 8'h00;
        temp1 = 8'h00;
        temp2 = 8'h00;

        // Reset state
        do_reset();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);

        // 1: single core-0 packet
        temp0 = 8'h32;
        req   = 3'b001;
        wait_grant(3'b001, "t1", waited);
        chk("t1_latency", 32'(waited), 32'd1);
        req = 3'b000;
        finish_packet(32'h97_32_00_A5, 3'b000, "t1");

        // 2: round robin with everyone requesting continuously
        do_reset();
        temp0 = 8'h40; temp1 = 8'h40; temp2 = 8'h40;
        req   = 3'b111;
        wait_grant(3'b001, "t2a", waited);
        finish_packet(32'hE5_40_00_A5, 3'b111, "t2a");
        wait_grant(3'b010, "t2b", waited);
        chk("t2b_spacing", 32'(waited), 32'd1);
        finish_packet(32'hE4_40_01_A5, 3'b111, "t2b");
        wait_grant(3'b100, "t2c", waited);
        chk("t2c_spacing", 32'(waited), 32'd1);
        finish_packet(32'hE7_40_02_A5, 3'b111, "t2c");
        wait_grant(3'b001, "t2d", waited);
        finish_packet(32'hE5_40_00_A5, 3'b000, "t2d");

        // 3: alarmed core 2 pre-empts core 0
        do_reset();
        temp0 = 8'h40; temp2 = 8'h5A;
        req   = 3'b101;
        wait_grant(3'b100, "t3a", waited);
        req = 3'b001;
        finish_packet(32'h7D_5A_82_A5, 3'b001, "t3a");
        wait_grant(3'b001, "t3b", waited);
        finish_packet(32'hE5_40_00_A5, 3'b000, "t3b");

        // 4: reset during bit 15 truncates the frame
        do_reset();
        temp0 = 8'h32;
        req   = 3'b001;
        wait_grant(3'b001, "t4a", waited);
        repeat (15) @(negedge tranclk);
        rst = 1'b1;
        req = 3'b000;
        @(negedge tranclk);
        chk("t4_rst_tx", 32'(tx), 32'd1);
        chk("t4_rst_ack", 32'(ack), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        rst   = 1'b0;
        temp1 = 8'h21;
        req   = 3'b010;
        wait_grant(3'b010, "t4b", waited);
        finish_packet(32'h85_21_01_A5, 3'b000, "t4b");

        // 5: core 1 withdraws before it is ever granted
        do_reset();
        temp0 = 8'h10;
        req   = 3'b001;
        wait_grant(3'b001, "t5", waited);
        req = 3'b010;
        finish_packet(32'hB5_10_00_A5, 3'b000, "t5");
        bad_ack = 0;
        bad_tx  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge tranclk);
            if (ack != 3'b000) bad_ack++;
            if (tx !== 1'b1) bad_tx++;
        end
        chk("t5_no_ack", 32'(bad_ack), 32'd0);
        chk("t5_line_high", 32'(bad_tx), 32'd0);

        // 6: temperature change after ack does not disturb the latched sample
        do_reset();
        temp0 = 8'h32;
        req   = 3'b001;
        wait_grant(3'b001, "t6a", waited);
        temp0 = 8'hFF;
        finish_packet(32'h97_32_00_A5, 3'b001, "t6a");
        wait_grant(3'b001, "t6b", waited);
        finish_packet(32'hDA_FF_80_A5, 3'b000, "t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
